mm_seq_ctrl: RTL and testbench

- Sequencer for an N x N systolic array of floating-point multiply-accumulate processing elements.
- Each element has a pulse-enabled multiplier, a pulse-enabled adder and an output register.
- Runs one matrix product per start/done handshake:
  - clears the accumulators;
  - issues A/B operand-buffer reads;
  - advances the skewed operand wavefront, paced so the adder feedback loop never overlaps;
  - collects a sticky overflow status.
- Sits between the host control interface and the array; the array edge skew delay lines and the operand buffers are external.

---
 rtl/mm_seq_if.sv | 41 ++++
 rtl/mm_seq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mm_seq_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mm_seq_if.sv
// Control bundle between the host/array and the systolic-array sequencer.
// Optional perf_cycles member is present only when MM_SEQ_PERF_EN is defined.
interface mm_seq_if #(
  parameter int unsigned ADDR_W = 2
);
  logic              start;
  logic              busy;
  logic              done;
  logic              clr_acc;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              shift_en;
  logic              mult_en;
  logic              add_en;
  logic              out_en;
  logic              array_overflow;
  logic              overflow_flag;
`ifdef MM_SEQ_PERF_EN
  logic [15:0]       perf_cycles;
`endif

  // Sequencer side
  modport master (
    input  start, array_overflow,
    output busy, done, clr_acc, rd_en, rd_addr, shift_en,
           mult_en, add_en, out_en, overflow_flag
`ifdef MM_SEQ_PERF_EN
    , output perf_cycles
`endif
  );

  // Host / array side
  modport slave (
    output start, array_overflow,
    input  busy, done, clr_acc, rd_en, rd_addr, shift_en,
           mult_en, add_en, out_en, overflow_flag
`ifdef MM_SEQ_PERF_EN
    , input perf_cycles
`endif
  );
endinterface

// File: rtl/mm_seq_ctrl.sv
// Sequencer for an N x N systolic FP MAC array: clear, II-paced beats, drain, done.
// Optional busy-cycle counter enabled by defining MM_SEQ_PERF_EN.
module mm_seq_ctrl #(
  parameter int unsigned N        = 4,
  parameter int unsigned MULT_LAT = 3,
  parameter int unsigned ADD_LAT  = 3,
  parameter int unsigned II       = 4,
  parameter int unsigned ADDR_W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic      clk,
  input  logic      reset,
  mm_seq_if.master  bus
);

  localparam int unsigned NBEATS = 3 * N - 2;
  localparam int unsigned BEAT_W = $clog2(NBEATS + 1);
  localparam int unsigned II_W   = $clog2(II + 1);
  localparam logic [ADD_LAT-1:0] OUT_PRE_MASK = ADD_LAT'((64'd1 << (ADD_LAT - 1)) - 64'd1);

  // Adder feedback must settle before the next beat's add_en
  if (II < ADD_LAT + 1) begin : g_bad_ii
    $error("mm_seq_ctrl: II must be >= ADD_LAT+1");
  end
  if (MULT_LAT < 1 || ADD_LAT < 1) begin : g_bad_lat
    $error("mm_seq_ctrl: MULT_LAT and ADD_LAT must be >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [II_W-1:0]     ii_q, ii_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                clr_q, clr_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                shift_q, shift_d;
  logic                ovf_q, ovf_d;
  logic                mult_q;
  logic [MULT_LAT-1:0] add_dly_q;
  logic [ADD_LAT-1:0]  out_dly_q;
  logic                add_en;
  logic                out_en;
  logic                last_out;

  assign add_en = add_dly_q[MULT_LAT-1];
  assign out_en = out_dly_q[ADD_LAT-1];

  // Final out_en: nothing else left anywhere in the pulse pipeline
  assign last_out = out_en && !shift_q && !mult_q && (add_dly_q == '0)
                    && ((out_dly_q & OUT_PRE_MASK) == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      ii_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      clr_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      shift_q   <= 1'b0;
      ovf_q     <= 1'b0;
      mult_q    <= 1'b0;
      add_dly_q <= '0;
      out_dly_q <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      ii_q      <= ii_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      clr_q     <= clr_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      shift_q   <= shift_d;
      ovf_q     <= ovf_d;
      // Beat pulse delay lines: read latency, then multiplier, then adder
      mult_q    <= shift_q;
      add_dly_q <= MULT_LAT'({add_dly_q, mult_q});
      out_dly_q <= ADD_LAT'({out_dly_q, add_en});
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    ii_d      = ii_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    clr_d     = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    shift_d   = 1'b0;
    ovf_d     = ovf_q | (bus.array_overflow & out_en);

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CLEAR;
          busy_d  = 1'b1;
          clr_d   = 1'b1;
          ovf_d   = 1'b0;
        end
      end
      S_CLEAR: begin
        // Beat 0 issues on RUN entry
        shift_d   = 1'b1;
        rd_en_d   = 1'b1;
        rd_addr_d = '0;
        beat_d    = BEAT_W'(1);
        ii_d      = II_W'(II - 1);
        state_d   = (NBEATS == 1) ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        if (ii_q == '0) begin
          shift_d = 1'b1;
          if (beat_q < BEAT_W'(N)) begin
            rd_en_d   = 1'b1;
            rd_addr_d = ADDR_W'(beat_q);
          end
          beat_d = beat_q + 1'b1;
          ii_d   = II_W'(II - 1);
          if (beat_q == BEAT_W'(NBEATS - 1)) state_d = S_DRAIN;
        end else begin
          ii_d = ii_q - 1'b1;
        end
      end
      S_DRAIN: begin
        if (last_out) begin
          state_d = S_FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.clr_acc       = clr_q;
  assign bus.rd_en         = rd_en_q;
  assign bus.rd_addr       = rd_addr_q;
  assign bus.shift_en      = shift_q;
  assign bus.mult_en       = mult_q;
  assign bus.add_en        = add_en;
  assign bus.out_en        = out_en;
  assign bus.overflow_flag = ovf_q;

`ifdef MM_SEQ_PERF_EN
  logic [15:0] perf_q;

  // Busy-cycle counter, restarted on accept, saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= '0;
    end else if (state_q == S_IDLE && bus.start) begin
      perf_q <= '0;
    end else if (busy_q && perf_q != 16'hFFFF) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign bus.perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Directed bench for mm_seq_ctrl: default N=4 instance plus an N=1 instance.
module tb_mm_seq_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  logic ovf_exp;

  mm_seq_if #(.ADDR_W(2)) b4 ();
  mm_seq_if #(.ADDR_W(1)) b1 ();

  mm_seq_ctrl #(.N(4), .MULT_LAT(3), .ADD_LAT(3), .II(4), .ADDR_W(2)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (b4)
  );

  mm_seq_ctrl #(.N(1), .MULT_LAT(3), .ADD_LAT(3), .II(4), .ADDR_W(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [10:0] obs4();
    return {b4.busy, b4.done, b4.clr_acc, b4.rd_en, b4.rd_addr, b4.shift_en,
            b4.mult_en, b4.add_en, b4.out_en, b4.overflow_flag};
  endfunction

  function automatic logic [9:0] obs1();
    return {b1.busy, b1.done, b1.clr_acc, b1.rd_en, b1.rd_addr, b1.shift_en,
            b1.mult_en, b1.add_en, b1.out_en, b1.overflow_flag};
  endfunction

  function automatic logic pulse(input int r, input int first, input int last);
    return (r >= first) && (r <= last) && (((r - first) % 4) == 0);
  endfunction

  // Expected N=4 outputs r cycles after the start sample (r = 1..47)
  function automatic logic [10:0] exp4(input int r, input logic [1:0] a0, input logic ov);
    logic       sh;
    logic       rd;
    logic [1:0] ad;
    sh = pulse(r, 2, 38);
    rd = sh && (r <= 14);
    if (r < 2)        ad = a0;
    else if (r >= 14) ad = 2'd3;
    else              ad = 2'((r - 2) / 4);
    return {(r >= 1 && r <= 45), (r == 46), (r == 1), rd, ad, sh,
            pulse(r, 3, 39), pulse(r, 6, 42), pulse(r, 9, 45), ov};
  endfunction

  function automatic logic [9:0] exp1(input int r);
    return {(r >= 1 && r <= 9), (r == 10), (r == 1), (r == 2), 1'b0, (r == 2),
            (r == 3), (r == 6), (r == 9), 1'b0};
  endfunction

  // One N=4 product from the current cycle (cycle 0); start pulsed again at r=20
  task automatic run4(input int ncyc, input logic [1:0] a0, input int ovf_cyc,
                      input bit hold, input string name);
    b4.start = 1'b1;
    for (int r = 1; r <= ncyc; r++) begin
      tick();
      if (r == 1) ovf_exp = 1'b0;
      check($sformatf("%s_r%0d", name, r), 32'(obs4()), 32'(exp4(r, a0, ovf_exp)));
`ifdef MM_SEQ_PERF_EN
      if (r == 47) check($sformatf("%s_perf", name), 32'(b4.perf_cycles), 32'd45);
`endif
      b4.start          = hold ? 1'b1 : (r == 20);
      b4.array_overflow = (r == ovf_cyc);
      if (r == ovf_cyc && pulse(r, 9, 45)) ovf_exp = 1'b1;
    end
  endtask

  initial begin
    n_checks          = 0;
    n_pass            = 0;
    ovf_exp           = 1'b0;
    reset             = 1'b1;
    b4.start          = 1'b0;
    b4.array_overflow = 1'b0;
    b1.start          = 1'b0;
    b1.array_overflow = 1'b0;

    tick();
    tick();
    check("reset4", 32'(obs4()), 32'd0);
    check("reset1", 32'(obs1()), 32'd0);
    reset = 1'b0;
    tick();
    check("idle4", 32'(obs4()), 32'd0);

    // Overflow on 3rd out_en sticks past done
    run4(47, 2'd0, 17, 1'b0, "A");
    // Overflow outside out_en ignored; start held high across products
    run4(47, 2'd3, 19, 1'b1, "B");
    run4(47, 2'd3, 0, 1'b0, "C");

    // Abort by reset at cycle 20
    run4(20, 2'd3, 17, 1'b0, "D");
    #2 reset = 1'b1;
    #1 check("rst_async", 32'(obs4()), 32'd0);
    b4.start          = 1'b0;
    b4.array_overflow = 1'b0;
    for (int r = 21; r <= 25; r++) begin
      tick();
      check($sformatf("rst_r%0d", r), 32'(obs4()), 32'd0);
      if (r == 22) reset = 1'b0;
    end
    run4(47, 2'd0, 0, 1'b0, "E");

    // N=1 boundary
    b1.start = 1'b1;
    for (int r = 1; r <= 11; r++) begin
      tick();
      b1.start = 1'b0;
      check($sformatf("n1_r%0d", r), 32'(obs1()), 32'(exp1(r)));
`ifdef MM_SEQ_PERF_EN
      if (r >= 10) check($sformatf("n1_perf_r%0d", r), 32'(b1.perf_cycles), 32'd9);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
